ifetch_ctrl: RTL

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

---
 rtl/ifetch_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: walks a fetch PC through instruction memory,
// buffers fetched words in a two-entry queue for decode, and handles
// redirects (including a sticky fault on misaligned redirect targets).
module ifetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [63:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fault,
  output logic [63:0] fault_pc,
  output logic [31:0] retired_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] fetchPc_q, fetchPc_d;
  logic [63:0] pc0_q, pc0_d;
  logic [31:0] instr0_q, instr0_d;
  logic [63:0] pc1_q, pc1_d;
  logic [31:0] instr1_q, instr1_d;
  logic [1:0]  count_q, count_d;
  logic        fault_q, fault_d;
  logic [63:0] faultPc_q, faultPc_d;
  logic [31:0] retiredCnt_q, retiredCnt_d;

  logic        handshake;
  logic        redirectMisaligned;
  logic        popEn;
  logic        pushEn;
  logic [1:0]  countAfterPop;

  // Entry 0 is always the queue head, so decode sees registered data only.
  assign imem_pc     = fetchPc_q;
  assign if_valid    = (count_q != 2'd0);
  assign if_instr    = instr0_q;
  assign if_pc       = pc0_q;
  assign fault       = fault_q;
  assign fault_pc    = faultPc_q;
  assign retired_cnt = retiredCnt_q;

  // Next-state logic: redirects win over queue traffic; a handshake in the
  // same cycle as a redirect still counts even though its entry is flushed.
  always_comb begin
    state_d       = state_q;
    fetchPc_d     = fetchPc_q;
    pc0_d         = pc0_q;
    instr0_d      = instr0_q;
    pc1_d         = pc1_q;
    instr1_d      = instr1_q;
    count_d       = count_q;
    fault_d       = fault_q;
    faultPc_d     = faultPc_q;
    retiredCnt_d  = retiredCnt_q;
    popEn         = 1'b0;
    pushEn        = 1'b0;
    countAfterPop = count_q;

    handshake          = (state_q != FAULT) && (count_q != 2'd0) && id_ready;
    redirectMisaligned = (redirect_pc[1:0] != 2'b00);

    if (handshake) begin
      retiredCnt_d = retiredCnt_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          count_d = 2'd0;
          if (redirectMisaligned) begin
            state_d   = FAULT;
            fault_d   = 1'b1;
            faultPc_d = redirect_pc;
          end else begin
            fetchPc_d = redirect_pc;
            if (start) begin
              state_d = FETCH;
            end
          end
        end else if (start) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (redirect_valid) begin
          count_d = 2'd0;
          if (redirectMisaligned) begin
            state_d   = FAULT;
            fault_d   = 1'b1;
            faultPc_d = redirect_pc;
          end else begin
            fetchPc_d = redirect_pc;
          end
        end else begin
          popEn         = handshake;
          countAfterPop = count_q - {1'b0, popEn};
          pushEn        = (count_q != 2'd2) || popEn;
          if (popEn) begin
            pc0_d    = pc1_q;
            instr0_d = instr1_q;
          end
          if (pushEn) begin
            if (countAfterPop == 2'd0) begin
              pc0_d    = fetchPc_q;
              instr0_d = imem_instr;
            end else begin
              pc1_d    = fetchPc_q;
              instr1_d = imem_instr;
            end
            fetchPc_d = fetchPc_q + 64'd4;
          end
          count_d = countAfterPop + {1'b0, pushEn};
        end
      end

      FAULT: begin
        count_d = 2'd0;
      end

      default: begin
        state_d = IDLE;
        count_d = 2'd0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetchPc_q    <= RESET_PC;
      pc0_q        <= 64'h0;
      instr0_q     <= 32'h0;
      pc1_q        <= 64'h0;
      instr1_q     <= 32'h0;
      count_q      <= 2'd0;
      fault_q      <= 1'b0;
      faultPc_q    <= 64'h0;
      retiredCnt_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      fetchPc_q    <= fetchPc_d;
      pc0_q        <= pc0_d;
      instr0_q     <= instr0_d;
      pc1_q        <= pc1_d;
      instr1_q     <= instr1_d;
      count_q      <= count_d;
      fault_q      <= fault_d;
      faultPc_q    <= faultPc_d;
      retiredCnt_q <= retiredCnt_d;
    end
  end

endmodule
